// File: rtl/bcd_to_bin_seq_pkg.sv
// Shared types and constants for the BCD-to-binary converter.
// State encoding, digit geometry, correction constants, digit check.
package bcd_to_bin_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int          DIG_W     = 4;
  localparam logic [3:0]  MAX_DIGIT = 4'd9;
  localparam logic [3:0]  CORR_TH   = 4'd8;
  localparam logic [3:0]  CORR_OFF  = 4'd3;

  function automatic logic digit_bad(
    input logic [3:0] d
  );
    return d > MAX_DIGIT;
  endfunction

endpackage

// File: rtl/bcd_to_bin_seq_undabble.sv
// Reverse double-dabble cell: subtract 3 from a digit that is >= 8.
// Ports: digit (raw shifted digit), fixed (corrected digit).
module bcd_to_bin_seq_undabble
  import bcd_to_bin_seq_pkg::*;
(
  input  logic [3:0] digit,
  output logic [3:0] fixed
);

  assign fixed = (digit >= CORR_TH) ? digit - CORR_OFF : digit;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Iterative packed-BCD to binary converter, valid/ready on both sides.
// Ports: clk, rst_n, in_valid/in_ready/bcd_in, out_valid/out_ready/bin_out/err.
// Macro BCD2BIN_CHECK_EN enables the invalid-digit flag on err.
module bcd_to_bin_seq
  import bcd_to_bin_seq_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DIG_W*DIGITS-1:0]   bcd_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [BIN_W-1:0]          bin_out,
  output logic                      err
);

  localparam int BW = DIG_W * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);

  state_t          state;
  state_t          state_nxt;
  logic [BW-1:0]   bcd_reg;
  logic [BIN_W-1:0] bin_reg;
  logic [CW-1:0]   cnt;
  logic [BW-1:0]   bcd_sh;
  logic [BW-1:0]   bcd_fix;
  logic [BIN_W-1:0] bin_sh;
  logic            accept;
  logic            last;

  assign accept = in_valid && (state == ST_IDLE);
  assign last   = cnt == CW'(BIN_W - 1);

  // One bit moves from the BCD side into the binary side per shift.
  assign bcd_sh = {1'b0, bcd_reg[BW-1:1]};
  assign bin_sh = {bcd_reg[0], bin_reg[BIN_W-1:1]};

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bcd_to_bin_seq_undabble u_cell (
      .digit (bcd_sh[g*DIG_W +: DIG_W]),
      .fixed (bcd_fix[g*DIG_W +: DIG_W])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (in_valid)  state_nxt = ST_SHIFT;
      ST_SHIFT: if (last)      state_nxt = ST_DONE;
      ST_DONE:  if (out_ready) state_nxt = ST_IDLE;
      default:                 state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_reg <= '0;
      bin_reg <= '0;
      cnt     <= '0;
    end else if (accept) begin
      bcd_reg <= bcd_in;
      bin_reg <= '0;
      cnt     <= '0;
    end else if (state == ST_SHIFT) begin
      bcd_reg <= bcd_fix;
      bin_reg <= bin_sh;
      cnt     <= cnt + CW'(1);
    end
  end

  assign in_ready  = state == ST_IDLE;
  assign out_valid = state == ST_DONE;
  assign bin_out   = bin_reg;

`ifdef BCD2BIN_CHECK_EN
  logic err_reg;
  logic any_bad;

  always_comb begin
    any_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (digit_bad(bcd_in[i*DIG_W +: DIG_W])) any_bad = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      err_reg <= 1'b0;
    else if (accept) err_reg <= any_bad;
  end

  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed bench for bcd_to_bin_seq (DIGITS=2, BIN_W=7).
// Ports driven: clk, rst_n, in_valid, bcd_in, out_ready.
module tb_bcd_to_bin_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] bcd_in = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [6:0] bin_out;
  logic       err;

  int total = 0;
  int bad = 0;

  bcd_to_bin_seq #(.DIGITS(2), .BIN_W(7)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bcd_in    (bcd_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bin_out   (bin_out),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge
  // where out_valid is first seen, lat = edges after the accept edge.
  task automatic convert(
    input  logic [7:0] v,
    output int         lat
  );
    in_valid = 1'b1;
    bcd_in   = v;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("timeout", {31'd0, out_valid}, 32'd1);
  endtask

  initial begin
    int lat;
    int exp_v;

    // reset state
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_bin_out", {25'd0, bin_out}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 99 with out_ready held high
    convert(8'h99, lat);
    chk("lat_99", lat, 32'd7);
    chk("bin_99", {25'd0, bin_out}, 32'd99);
    chk("err_99", {31'd0, err}, 32'd0);
    chk("busy_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    chk("idle_after_99", {31'd0, in_ready}, 32'd1);
    chk("ov_after_99", {31'd0, out_valid}, 32'd0);

    // sweep all valid two-digit inputs
    for (int hi = 0; hi < 10; hi++) begin
      for (int lo = 0; lo < 10; lo++) begin
        exp_v = hi * 10 + lo;
        convert(8'(hi * 16 + lo), lat);
        chk($sformatf("bin_%0d%0d", hi, lo), {25'd0, bin_out}, exp_v);
        @(negedge clk);
      end
    end

    // back-pressure on 45
    out_ready = 1'b0;
    convert(8'h45, lat);
    chk("lat_45", lat, 32'd7);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      bcd_in   = 8'h11;
      @(negedge clk);
      chk("bp_ov", {31'd0, out_valid}, 32'd1);
      chk("bp_bin", {25'd0, bin_out}, 32'd45);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rel_ov", {31'd0, out_valid}, 32'd0);
    repeat (10) @(negedge clk);
    chk("no_queue_ov", {31'd0, out_valid}, 32'd0);
    chk("no_queue_rdy", {31'd0, in_ready}, 32'd1);

    // reset during shift of 57
    in_valid = 1'b1;
    bcd_in   = 8'h57;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ov", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_rdy", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_bin", {25'd0, bin_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ov", {31'd0, out_valid}, 32'd0);
    convert(8'h12, lat);
    chk("lat_12", lat, 32'd7);
    chk("bin_12", {25'd0, bin_out}, 32'd12);
    @(negedge clk);

    // invalid digit handling
    convert(8'h0A, lat);
`ifdef BCD2BIN_CHECK_EN
    chk("err_0a", {31'd0, err}, 32'd1);
`else
    chk("err_0a_off", {31'd0, err}, 32'd0);
`endif
    @(negedge clk);
    convert(8'h10, lat);
    chk("err_10", {31'd0, err}, 32'd0);
    chk("bin_10", {25'd0, bin_out}, 32'd10);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
